// File: rtl/arp_pkg.sv
// -----------------------------------------------------------------------------
// arp_pkg
// Shared types and helpers for the N-key arpeggiator.
//   arp_mode_t  : sequencing mode encoding (matches the 2-bit mode port)
//   arp_state_t : top-level FSM states
//   arp_dir_t   : ping-pong travel direction
//   key_sel_t   : result of a held-key search (found flag + index)
//   find_at_or_above / find_at_or_below : priority searches over a key vector
//   lfsr_next   : one step of the 16-bit random-mode LFSR
// -----------------------------------------------------------------------------
package arp_pkg;

    typedef enum logic [1:0] {
        MODE_UP       = 2'd0,
        MODE_DOWN     = 2'd1,
        MODE_PINGPONG = 2'd2,
        MODE_RANDOM   = 2'd3
    } arp_mode_t;

    typedef enum logic [1:0] {
        ST_BYPASS = 2'd0,
        ST_WAIT   = 2'd1,
        ST_PLAY   = 2'd2
    } arp_state_t;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } arp_dir_t;

    // Searches always run over a 32-bit zero-extended key vector so one pair
    // of helpers serves every NUM_KEYS up to the supported maximum.
    localparam int MAX_KEYS = 32;

    // Fibonacci taps 16,14,13,11 in right-shift form: feedback is the XOR of
    // bits 0,2,3,5 and enters at bit 15.
    localparam logic [15:0] LFSR_TAPS = 16'h002D;

    typedef struct packed {
        logic       found;
        logic [4:0] idx;
    } key_sel_t;

    // Lowest set bit of keys whose index is >= start. A start beyond the top
    // key simply finds nothing.
    function automatic key_sel_t find_at_or_above(logic [MAX_KEYS-1:0] keys, int start);
        key_sel_t sel;
        sel = '0;
        // Scan downward so the last hit, i.e. the lowest index, wins.
        for (int i = MAX_KEYS - 1; i >= 0; i--) begin
            if (keys[i] && (i >= start)) begin
                sel.found = 1'b1;
                sel.idx   = 5'(i);
            end
        end
        return sel;
    endfunction

    // Highest set bit of keys whose index is <= start. A negative start finds
    // nothing.
    function automatic key_sel_t find_at_or_below(logic [MAX_KEYS-1:0] keys, int start);
        key_sel_t sel;
        sel = '0;
        for (int i = 0; i < MAX_KEYS; i++) begin
            if (keys[i] && (i <= start)) begin
                sel.found = 1'b1;
                sel.idx   = 5'(i);
            end
        end
        return sel;
    endfunction

    function automatic logic [15:0] lfsr_next(logic [15:0] q);
        return {^(q & LFSR_TAPS), q[15:1]};
    endfunction

endpackage

// File: rtl/arpeggiator_n_next_key.sv
// -----------------------------------------------------------------------------
// arp_next_key
// Combinational successor logic: given the held keys and the current step,
// picks the key for the next step and the ping-pong direction after it.
// Ports:
//   keys_i      [NUM_KEYS-1:0] held-key vector
//   cur_idx_i   [IDX_W-1:0]    index of the current step's key
//   mode_i      [1:0]          arp_mode_t encoding
//   dir_i                      current ping-pong direction (arp_dir_t)
//   rnd_start_i [IDX_W-1:0]    random-mode search start (lfsr mod NUM_KEYS)
//   next_idx_o  [IDX_W-1:0]    key index for the next step
//   next_dir_o                 ping-pong direction after the step
// -----------------------------------------------------------------------------
module arp_next_key
    import arp_pkg::*;
#(
    parameter  int NUM_KEYS = 8,
    localparam int IDX_W    = $clog2(NUM_KEYS)
) (
    input  logic [NUM_KEYS-1:0] keys_i,
    input  logic [IDX_W-1:0]    cur_idx_i,
    input  logic [1:0]          mode_i,
    input  logic                dir_i,
    input  logic [IDX_W-1:0]    rnd_start_i,
    output logic [IDX_W-1:0]    next_idx_o,
    output logic                next_dir_o
);

    logic [MAX_KEYS-1:0] keys_ext;
    int                  cur_int;
    int                  rnd_int;
    key_sel_t            above_sel;
    key_sel_t            below_sel;
    key_sel_t            lowest_sel;
    key_sel_t            highest_sel;
    key_sel_t            rnd_sel;

    assign keys_ext = MAX_KEYS'(keys_i);
    assign cur_int  = int'(cur_idx_i);
    assign rnd_int  = int'(rnd_start_i);

    // Strictly above / strictly below the current key; cur_int - 1 may be -1,
    // which correctly yields "nothing below key 0".
    assign above_sel   = find_at_or_above(keys_ext, cur_int + 1);
    assign below_sel   = find_at_or_below(keys_ext, cur_int - 1);
    assign lowest_sel  = find_at_or_above(keys_ext, 0);
    assign highest_sel = find_at_or_below(keys_ext, MAX_KEYS - 1);
    assign rnd_sel     = find_at_or_above(keys_ext, rnd_int);

    always_comb begin
        // NOTE: every output gets a default before the case so no path
        // leaves it unassigned, which would otherwise infer a latch.
        next_idx_o = cur_idx_i;
        next_dir_o = dir_i;
        case (arp_mode_t'(mode_i))
            MODE_UP: begin
                if (above_sel.found)       next_idx_o = IDX_W'(above_sel.idx);
                else if (lowest_sel.found) next_idx_o = IDX_W'(lowest_sel.idx);
            end
            MODE_DOWN: begin
                if (below_sel.found)        next_idx_o = IDX_W'(below_sel.idx);
                else if (highest_sel.found) next_idx_o = IDX_W'(highest_sel.idx);
            end
            MODE_PINGPONG: begin
                // Continue in the current direction; bounce only when the end
                // is reached. A lone held key leaves index and dir untouched.
                if (dir_i == DIR_UP) begin
                    if (above_sel.found) begin
                        next_idx_o = IDX_W'(above_sel.idx);
                    end else if (below_sel.found) begin
                        next_idx_o = IDX_W'(below_sel.idx);
                        next_dir_o = DIR_DOWN;
                    end
                end else begin
                    if (below_sel.found) begin
                        next_idx_o = IDX_W'(below_sel.idx);
                    end else if (above_sel.found) begin
                        next_idx_o = IDX_W'(above_sel.idx);
                        next_dir_o = DIR_UP;
                    end
                end
            end
            MODE_RANDOM: begin
                // Independent of cur_idx, so the same key may repeat.
                if (rnd_sel.found)         next_idx_o = IDX_W'(rnd_sel.idx);
                else if (lowest_sel.found) next_idx_o = IDX_W'(lowest_sel.idx);
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/arpeggiator_n.sv
// -----------------------------------------------------------------------------
// arpeggiator_n
// N-key arpeggiator between the key scanner and the voice allocator. Plays the
// held keys one at a time (up / down / ping-pong / random) with programmable
// step and gate lengths, or passes keys straight through when disabled.
// Ports:
//   CLK                       system clock
//   RESET                     synchronous, active-high reset
//   enable                    1 = arpeggiate, 0 = bypass
//   mode       [1:0]          0 UP, 1 DOWN, 2 PINGPONG, 3 RANDOM
//   step_len   [CNT_W-1:0]    each step lasts step_len+1 cycles
//   gate_len   [CNT_W-1:0]    cycles per step during which the note sounds
//   keys_in    [NUM_KEYS-1:0] held-key vector
//   keys_out   [NUM_KEYS-1:0] registered key-on vector to the voices
//   cur_idx    [IDX_W-1:0]    index of the current step's key
//   step_pulse                one-cycle strobe on every step advance
// -----------------------------------------------------------------------------
module arpeggiator_n
    import arp_pkg::*;
#(
    parameter  int          NUM_KEYS  = 8,
    parameter  int          CNT_W     = 16,
    parameter  logic [15:0] LFSR_SEED = 16'hACE1,
    localparam int          IDX_W     = $clog2(NUM_KEYS)
) (
    input  logic                CLK,
    input  logic                RESET,
    input  logic                enable,
    input  logic [1:0]          mode,
    input  logic [CNT_W-1:0]    step_len,
    input  logic [CNT_W-1:0]    gate_len,
    input  logic [NUM_KEYS-1:0] keys_in,
    output logic [NUM_KEYS-1:0] keys_out,
    output logic [IDX_W-1:0]    cur_idx,
    output logic                step_pulse
);

    arp_state_t          state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    arp_dir_t            dir_q, dir_d;
    logic [15:0]         lfsr_q;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [NUM_KEYS-1:0] out_q, out_d;
    logic                pulse_q, pulse_d;

    logic                any_key;
    logic                advance;
    logic [IDX_W-1:0]    rnd_start;
    logic [IDX_W-1:0]    next_idx;
    logic                next_dir;
    logic [IDX_W-1:0]    first_idx;
    logic [MAX_KEYS-1:0] keys_ext;
    key_sel_t            first_sel;

    assign any_key   = |keys_in;
    assign keys_ext  = MAX_KEYS'(keys_in);
    assign rnd_start = IDX_W'(lfsr_q % 16'(NUM_KEYS));

    // ">=" rather than "==" so that shortening step_len below the running
    // count ends the step on the very next cycle; releasing the sounding key
    // also ends it immediately.
    assign advance = (cnt_q >= step_len) || !keys_in[idx_q];

    arp_next_key #(
        .NUM_KEYS (NUM_KEYS)
    ) u_next_key (
        .keys_i      (keys_in),
        .cur_idx_i   (idx_q),
        .mode_i      (mode),
        .dir_i       (dir_q),
        .rnd_start_i (rnd_start),
        .next_idx_o  (next_idx),
        .next_dir_o  (next_dir)
    );

    // Starting key when entering PLAY from BYPASS or WAIT.
    always_comb begin
        case (arp_mode_t'(mode))
            MODE_DOWN:   first_sel = find_at_or_below(keys_ext, MAX_KEYS - 1);
            MODE_RANDOM: begin
                first_sel = find_at_or_above(keys_ext, int'(rnd_start));
                if (!first_sel.found) first_sel = find_at_or_above(keys_ext, 0);
            end
            default:     first_sel = find_at_or_above(keys_ext, 0);
        endcase
        first_idx = first_sel.found ? IDX_W'(first_sel.idx) : '0;
    end

    // Next-state and output logic. Outputs are computed from the next-state
    // index and count so keys_out, cur_idx and step_pulse line up on the same
    // cycle after the register.
    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        dir_d   = dir_q;
        idx_d   = idx_q;
        pulse_d = 1'b0;
        out_d   = '0;

        if (!enable) begin
            state_d = ST_BYPASS;
            dir_d   = DIR_UP;
        end else if (!any_key) begin
            // Covers BYPASS, WAIT and PLAY alike: nothing held means silence.
            state_d = ST_WAIT;
        end else if (state_q != ST_PLAY) begin
            state_d = ST_PLAY;
            idx_d   = first_idx;
            pulse_d = 1'b1;
        end else if (advance) begin
            idx_d   = next_idx;
            dir_d   = arp_dir_t'(next_dir);
            pulse_d = 1'b1;
        end else begin
            cnt_d = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
        end

        if (state_d == ST_BYPASS) begin
            out_d = keys_in;
        end else if ((state_d == ST_PLAY) && (cnt_d < gate_len) && keys_in[idx_d]) begin
            out_d = NUM_KEYS'(1) << idx_d;
        end
    end

    always_ff @(posedge CLK) begin
        // NOTE: non-blocking assignments here so every register samples the
        // pre-edge values regardless of statement order.
        if (RESET) begin
            state_q <= ST_BYPASS;
            cnt_q   <= '0;
            dir_q   <= DIR_UP;
            lfsr_q  <= LFSR_SEED;
            idx_q   <= '0;
            out_q   <= '0;
            pulse_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dir_q   <= dir_d;
            lfsr_q  <= lfsr_next(lfsr_q);
            idx_q   <= idx_d;
            out_q   <= out_d;
            pulse_q <= pulse_d;
        end
    end

    assign keys_out   = out_q;
    assign cur_idx    = idx_q;
    assign step_pulse = pulse_q;

endmodule

// File: tb/tb_arpeggiator_n.sv
// -----------------------------------------------------------------------------
// tb_arpeggiator_n
// Directed and randomized bench for arpeggiator_n (NUM_KEYS=8, CNT_W=16).
// A cycle reference model built from the behavioural rules (circular and
// linear key walks, integer counters) predicts every output each cycle;
// directed steps additionally check the documented sequences.
// -----------------------------------------------------------------------------
module tb_arpeggiator_n;

    localparam int          NK      = 8;
    localparam int          CW      = 16;
    localparam logic [15:0] SEED    = 16'hACE1;
    localparam int          CNT_MAX = (1 << CW) - 1;

    logic          CLK = 1'b0;
    logic          RESET;
    logic          enable;
    logic [1:0]    mode;
    logic [CW-1:0] step_len;
    logic [CW-1:0] gate_len;
    logic [NK-1:0] keys_in;
    logic [NK-1:0] keys_out;
    logic [2:0]    cur_idx;
    logic          step_pulse;

    arpeggiator_n #(
        .NUM_KEYS  (NK),
        .CNT_W     (CW),
        .LFSR_SEED (SEED)
    ) dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .enable     (enable),
        .mode       (mode),
        .step_len   (step_len),
        .gate_len   (gate_len),
        .keys_in    (keys_in),
        .keys_out   (keys_out),
        .cur_idx    (cur_idx),
        .step_pulse (step_pulse)
    );

    always #5 CLK = ~CLK;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model state: m_state 0 bypass, 1 waiting, 2 playing;
    // m_dir is +1 (up) or -1 (down).
    int            m_state, m_cnt, m_dir, m_idx;
    logic [15:0]   m_lfsr;
    logic [NK-1:0] m_out;
    logic          m_pulse;

    int seq[$];
    int mseq[$];
    int ptime[$];
    int golden[$];
    int hi_cnt, n_ticks;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // First held key visited walking circularly from 'from' in steps of dir.
    function automatic int circ(logic [NK-1:0] k, int from, int dir);
        for (int d = 1; d <= NK; d++) begin
            int j;
            j = (((from + dir * d) % NK) + NK) % NK;
            if (k[j]) return j;
        end
        return from;
    endfunction

    // First held key walking linearly (no wrap) from 'from' in direction dir.
    function automatic int scan(logic [NK-1:0] k, int from, int dir);
        for (int j = from + dir; j >= 0 && j < NK; j += dir)
            if (k[j]) return j;
        return -1;
    endfunction

    function automatic int rand_pick(logic [NK-1:0] k, int r);
        for (int d = 0; d < NK; d++)
            if (k[(r + d) % NK]) return (r + d) % NK;
        return 0;
    endfunction

    task automatic model_tick();
        int v, b, rnd, j;
        v   = int'(m_lfsr);
        rnd = v % NK;
        m_pulse = 1'b0;
        if (RESET) begin
            m_state = 0; m_cnt = 0; m_dir = 1; m_idx = 0;
            m_out = '0; m_lfsr = SEED;
            return;
        end
        b = (v ^ (v >> 2) ^ (v >> 3) ^ (v >> 5)) & 1;
        m_lfsr = 16'((v >> 1) | (b << 15));
        if (!enable) begin
            m_state = 0; m_out = keys_in; m_cnt = 0; m_dir = 1;
            return;
        end
        if (keys_in == '0) begin
            m_state = 1; m_out = '0; m_cnt = 0;
            return;
        end
        if (m_state != 2) begin
            m_state = 2; m_cnt = 0; m_pulse = 1'b1;
            case (mode)
                2'd1:    m_idx = circ(keys_in, NK, -1);
                2'd3:    m_idx = rand_pick(keys_in, rnd);
                default: m_idx = circ(keys_in, -1, 1);
            endcase
        end else if (m_cnt >= int'(step_len) || !keys_in[m_idx]) begin
            m_cnt = 0; m_pulse = 1'b1;
            case (mode)
                2'd0: m_idx = circ(keys_in, m_idx, 1);
                2'd1: m_idx = circ(keys_in, m_idx, -1);
                2'd2: begin
                    j = scan(keys_in, m_idx, m_dir);
                    if (j < 0) begin
                        j = scan(keys_in, m_idx, -m_dir);
                        if (j >= 0) m_dir = -m_dir;
                        else        j = m_idx;
                    end
                    m_idx = j;
                end
                default: m_idx = rand_pick(keys_in, rnd);
            endcase
        end else if (m_cnt < CNT_MAX) begin
            m_cnt++;
        end
        m_out = (m_cnt < int'(gate_len) && keys_in[m_idx]) ? (NK'(1) << m_idx) : '0;
    endtask

    task automatic tick();
        model_tick();
        @(posedge CLK);
        #1;
        check("keys_out", 32'(keys_out), 32'(m_out));
        check("cur_idx", 32'(cur_idx), m_idx);
        check("step_pulse", 32'(step_pulse), 32'(m_pulse));
    endtask

    task automatic clear();
        seq.delete(); mseq.delete(); ptime.delete();
        hi_cnt = 0; n_ticks = 0;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            n_ticks++;
            if (step_pulse) begin
                seq.push_back(int'(cur_idx));
                ptime.push_back(n_ticks);
            end
            if (m_pulse) mseq.push_back(m_idx);
            if (keys_out != '0) hi_cnt++;
        end
    endtask

    // Expected sequence packed as hex nibbles, first element most significant.
    task automatic expect_seq(input string tag, input int n, input logic [31:0] vals);
        check(tag, seq.size(), n);
        for (int i = 0; i < n; i++)
            check(tag, (i < seq.size()) ? seq[i] : -1, 32'(vals[4*(n-1-i) +: 4]));
    endtask

    task automatic expect_gap(input string tag, input int gap);
        check(tag, ptime.size() > 1, 1);
        for (int i = 1; i < ptime.size(); i++)
            check(tag, ptime[i] - ptime[i-1], gap);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        int prev, bad, saw3, saw7;

        // Reset state
        RESET = 1'b1; enable = 1'b0; mode = 2'd0;
        step_len = '0; gate_len = '0; keys_in = '0;
        tick(); tick();
        check("rst_keys_out", 32'(keys_out), 0);
        check("rst_pulse", 32'(step_pulse), 0);
        RESET = 1'b0;

        // Bypass: 1-cycle passthrough, no strobes
        keys_in = 8'b1010_0101;
        tick();
        check("bypass_keys", 32'(keys_out), 32'h0000_00A5);
        clear();
        for (int i = 0; i < 8; i++) begin
            keys_in = NK'($urandom_range(0, 255));
            run(1);
        end
        check("bypass_pulses", seq.size(), 0);

        // UP, keys {1,4,6}, step 3, gate 4 (legato)
        keys_in = 8'h52; step_len = 16'd3; gate_len = 16'd4; mode = 2'd0;
        tick();
        clear(); enable = 1'b1;
        run(16);
        expect_seq("up_seq", 4, 32'h1461);
        expect_gap("up_gap", 4);
        check("up_legato", hi_cnt, 16);

        // PINGPONG, keys {0,2,5}, step 1
        enable = 1'b0; keys_in = 8'h25; step_len = 16'd1; gate_len = 16'd1;
        tick();
        clear(); enable = 1'b1; mode = 2'd2;
        run(11);
        expect_seq("pp_seq", 6, 32'h025202);

        // DOWN, same keys
        enable = 1'b0;
        tick();
        clear(); enable = 1'b1; mode = 2'd1;
        run(7);
        expect_seq("down_seq", 4, 32'h5205);

        // PINGPONG with only key 3 held
        enable = 1'b0; keys_in = 8'h08;
        tick();
        clear(); enable = 1'b1; mode = 2'd2;
        run(7);
        expect_seq("solo_seq", 4, 32'h3333);
        expect_gap("solo_gap", 2);

        // Gate 2 of step 6: high 2, low 4
        enable = 1'b0; keys_in = 8'h02; mode = 2'd0; step_len = 16'd5; gate_len = 16'd2;
        tick();
        clear(); enable = 1'b1;
        run(12);
        expect_seq("gate_seq", 2, 32'h11);
        expect_gap("gate_gap", 6);
        check("gate_high", hi_cnt, 4);

        // Release of the sounding key, then release of all keys
        keys_in = 8'h12;
        run(8);
        prev = m_idx;
        keys_in = 8'h12 & ~(NK'(1) << prev);
        tick();
        check("rel_pulse", 32'(step_pulse), 1);
        check("rel_idx", 32'(cur_idx), (prev == 1) ? 4 : 1);
        keys_in = '0;
        tick();
        check("wait_keys", 32'(keys_out), 0);
        check("wait_pulse", 32'(step_pulse), 0);
        tick();
        check("wait_hold", 32'(keys_out), 0);

        // RANDOM, keys {3,7}: two identical runs from reset
        RESET = 1'b1; enable = 1'b1; mode = 2'd3; keys_in = 8'h88;
        step_len = 16'd0; gate_len = 16'd1;
        tick();
        RESET = 1'b0; clear();
        run(64);
        bad = 0; saw3 = 0; saw7 = 0;
        foreach (seq[i]) begin
            if (seq[i] == 3)      saw3 = 1;
            else if (seq[i] == 7) saw7 = 1;
            else                  bad++;
        end
        check("rand_count", seq.size(), 64);
        check("rand_bad", bad, 0);
        check("rand_saw3", saw3, 1);
        check("rand_saw7", saw7, 1);
        golden = mseq;
        RESET = 1'b1;
        tick();
        RESET = 1'b0; clear();
        run(64);
        check("rand_rep_n", seq.size(), golden.size());
        foreach (golden[i])
            check("rand_repeat", (i < seq.size()) ? seq[i] : -1, golden[i]);

        // RESET mid-step, then enable toggle
        mode = 2'd0; keys_in = 8'h52; step_len = 16'd3; gate_len = 16'd4;
        run(6);
        RESET = 1'b1;
        tick();
        check("rst_mid_keys", 32'(keys_out), 0);
        check("rst_mid_idx", 32'(cur_idx), 0);
        check("rst_mid_pulse", 32'(step_pulse), 0);
        RESET = 1'b0;
        tick();
        check("restart_pulse", 32'(step_pulse), 1);
        check("restart_idx", 32'(cur_idx), 1);
        run(2);
        enable = 1'b0;
        tick();
        check("toggle_bypass", 32'(keys_out), 32'h52);
        check("toggle_nopulse", 32'(step_pulse), 0);
        enable = 1'b1;
        tick();
        check("toggle_pulse", 32'(step_pulse), 1);
        check("toggle_idx", 32'(cur_idx), 1);
        check("toggle_keys", 32'(keys_out), 32'h02);
        clear();
        run(4);
        check("toggle_cnt", (ptime.size() > 0) ? ptime[0] : -1, 4);
        check("toggle_next", (seq.size() > 0) ? seq[0] : -1, 4);

        // Randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 9) == 0)  keys_in = NK'($urandom_range(0, 255)) & NK'($urandom_range(0, 255));
            if ($urandom_range(0, 19) == 0) mode = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 29) == 0) begin
                step_len = CW'($urandom_range(0, 4));
                gate_len = CW'($urandom_range(0, 5));
            end
            enable = ($urandom_range(0, 49) != 0);
            RESET  = ($urandom_range(0, 199) == 0);
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
